// File: rtl/vfd_compositor.sv
// vfd_compositor: per-pixel mask/background fetch from SDRAM, segment intensity
// lookup (binary or decaying phosphor) and RGB332 compositing into video RAM.
module vfd_compositor #(
   parameter int SCREEN_SIZE = 307200,
   parameter int ADDR_W      = 25,
   parameter int VADDR_W     = 19,
   parameter int GRIDS       = 10,
   parameter int SEGS        = 17,
   parameter int INT_W       = 4,
   parameter int DECAY_DIV   = 65536
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic               persist_en,
   input  logic [GRIDS-1:0]   grid_sel,
   input  logic [SEGS-1:0]    seg,
   input  logic               rdy,
   output logic [ADDR_W-1:0]  sdram_addr,
   output logic               sdram_rd,
   input  logic [7:0]         sdram_data,
   output logic [VADDR_W-1:0] vfd_addr,
   output logic [7:0]         vfd_dout,
   output logic               vfd_vram_we,
   output logic               frame_done
);

   localparam int PS_W = (DECAY_DIV > 2) ? $clog2(DECAY_DIV) : 1;
   localparam logic [PS_W-1:0]    PS_LAST    = PS_W'(DECAY_DIV - 1);
   localparam logic [INT_W-1:0]   IMAX       = '1;
   localparam logic [ADDR_W-1:0]  MASK_BASE  = ADDR_W'(SCREEN_SIZE);
   localparam logic [VADDR_W-1:0] LAST_PIX   = VADDR_W'(SCREEN_SIZE - 1);

   typedef enum logic [2:0] {S_IDLE, S_MREQ, S_MLAT, S_BREQ, S_BWR} state_t;

   state_t                                   state_q, state_d;
   logic [VADDR_W-1:0]                       p_q, p_d;
   logic [ADDR_W-1:0]                        sdram_addr_q, sdram_addr_d;
   logic                                     sdram_rd_q, sdram_rd_d;
   logic [VADDR_W-1:0]                       vfd_addr_q, vfd_addr_d;
   logic [7:0]                               vfd_dout_q, vfd_dout_d;
   logic                                     we_q, we_d;
   logic                                     done_q, done_d;
   logic [INT_W-1:0]                         isel_q, isel_d;
   logic [PS_W-1:0]                          pcnt_q, pcnt_d;
   logic [GRIDS-1:0][SEGS-1:0][INT_W-1:0]    inten_q, inten_d;

   logic                                     tick;
   logic                                     onehot;
   logic                                     dec_hit;
   int                                       dec_g, dec_s;
   logic [INT_W-1:0]                         mask_i;

   assign sdram_addr  = sdram_addr_q;
   assign sdram_rd    = sdram_rd_q;
   assign vfd_addr    = vfd_addr_q;
   assign vfd_dout    = vfd_dout_q;
   assign vfd_vram_we = we_q;
   assign frame_done  = done_q;

   // Full colour at MAX, dim mask at 0, otherwise each channel scaled by I and
   // floored at its dim value so a fading segment never drops below "dark".
   function automatic logic [7:0] composite(input logic [7:0] b, input logic [INT_W-1:0] i);
      logic [7:0]         dim;
      logic [INT_W+2:0]   pr, pg;
      logic [INT_W+1:0]   pb;
      logic [2:0]         sr, sg;
      logic [1:0]         sb;
      dim = b & 8'b100_100_10;
      pr  = {{INT_W{1'b0}}, b[7:5]} * {3'b000, i};
      pg  = {{INT_W{1'b0}}, b[4:2]} * {3'b000, i};
      pb  = {{INT_W{1'b0}}, b[1:0]} * {2'b00, i};
      sr  = pr[INT_W +: 3];
      sg  = pg[INT_W +: 3];
      sb  = pb[INT_W +: 2];
      if (sr < dim[7:5]) sr = dim[7:5];
      if (sg < dim[4:2]) sg = dim[4:2];
      if (sb < dim[1:0]) sb = dim[1:0];
      if (i == IMAX)
         composite = b;
      else if (i == '0)
         composite = dim;
      else
         composite = {sr, sg, sb};
   endfunction

   // Mask byte decode to (grid, segment) and intensity lookup; invalid codes read 0.
   always_comb begin
      dec_hit = 1'b1;
      dec_g   = 0;
      dec_s   = 0;
      mask_i  = '0;
      if (int'(sdram_data[7:4]) < GRIDS) begin
         dec_g = int'(sdram_data[7:4]);
         dec_s = int'(sdram_data[3:0]);
      end else if (sdram_data[7:4] == 4'd10) begin
         dec_g = int'(sdram_data[3:0]);
         dec_s = 16;
      end else begin
         dec_hit = 1'b0;
      end
      if (dec_g >= GRIDS || dec_s >= SEGS) dec_hit = 1'b0;
      for (int g = 0; g < GRIDS; g++)
         for (int s = 0; s < SEGS; s++)
            if (dec_hit && dec_g == g && dec_s == s) mask_i = inten_q[g][s];
   end

   // Decay prescaler and segment latch; latch is applied last so it wins over a tick.
   always_comb begin
      tick    = (pcnt_q == PS_LAST);
      pcnt_d  = tick ? '0 : pcnt_q + PS_W'(1);
      onehot  = (grid_sel != '0) && ((grid_sel & (grid_sel - GRIDS'(1))) == '0);
      inten_d = inten_q;
      if (tick && persist_en)
         for (int g = 0; g < GRIDS; g++)
            for (int s = 0; s < SEGS; s++)
               if (inten_q[g][s] != '0) inten_d[g][s] = inten_q[g][s] - INT_W'(1);
      if (onehot)
         for (int g = 0; g < GRIDS; g++)
            if (grid_sel[g])
               for (int s = 0; s < SEGS; s++)
                  if (seg[s])
                     inten_d[g][s] = IMAX;
                  else if (!persist_en)
                     inten_d[g][s] = '0;
   end

   // Pixel sequencer next state; every step waits for rdy.
   always_comb begin
      state_d = state_q;
      if (rdy) begin
         case (state_q)
            S_IDLE:  if (enable) state_d = S_MREQ;
            S_MREQ:  state_d = S_MLAT;
            S_MLAT:  state_d = S_BREQ;
            S_BREQ:  state_d = S_BWR;
            S_BWR:   state_d = (p_q == LAST_PIX) ? S_IDLE : S_MREQ;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Per-state datapath and registered outputs; write/done strobes self-clear.
   always_comb begin
      p_d          = p_q;
      sdram_addr_d = sdram_addr_q;
      sdram_rd_d   = sdram_rd_q;
      vfd_addr_d   = vfd_addr_q;
      vfd_dout_d   = vfd_dout_q;
      isel_d       = isel_q;
      we_d         = 1'b0;
      done_d       = 1'b0;
      if (rdy) begin
         case (state_q)
            S_IDLE: p_d = '0;
            S_MREQ: begin
               sdram_addr_d = MASK_BASE + ADDR_W'(p_q);
               sdram_rd_d   = 1'b1;
            end
            S_MLAT: begin
               sdram_rd_d = 1'b0;
               isel_d     = mask_i;
            end
            S_BREQ: begin
               sdram_addr_d = ADDR_W'(p_q);
               sdram_rd_d   = 1'b1;
            end
            S_BWR: begin
               sdram_rd_d = 1'b0;
               vfd_addr_d = p_q;
               vfd_dout_d = composite(sdram_data, isel_q);
               we_d       = 1'b1;
               if (p_q == LAST_PIX) done_d = 1'b1;
               else                 p_d    = p_q + VADDR_W'(1);
            end
            default: ;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Datapath, output and intensity registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         p_q          <= '0;
         sdram_addr_q <= '0;
         sdram_rd_q   <= 1'b0;
         vfd_addr_q   <= '0;
         vfd_dout_q   <= '0;
         we_q         <= 1'b0;
         done_q       <= 1'b0;
         isel_q       <= '0;
         pcnt_q       <= '0;
         inten_q      <= '0;
      end else begin
         p_q          <= p_d;
         sdram_addr_q <= sdram_addr_d;
         sdram_rd_q   <= sdram_rd_d;
         vfd_addr_q   <= vfd_addr_d;
         vfd_dout_q   <= vfd_dout_d;
         we_q         <= we_d;
         done_q       <= done_d;
         isel_q       <= isel_d;
         pcnt_q       <= pcnt_d;
         inten_q      <= inten_d;
      end
   end

endmodule

// File: tb/tb_vfd_compositor.sv
// Bench for vfd_compositor: SDRAM array model, behavioural intensity/composite
// reference, per-write scoreboard, directed scenarios and randomized stalls.
module tb_vfd_compositor;

   localparam int SS = 8;
   localparam int GR = 10;
   localparam int SG = 17;
   localparam int IW = 4;
   localparam int DD = 4;
   localparam int AW = 25;
   localparam int VW = 19;
   localparam int MAXI = (1 << IW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic          persist_en = 1'b0;
   logic          rdy = 1'b0;
   logic [GR-1:0] grid_sel = '0;
   logic [SG-1:0] seg = '0;
   logic [AW-1:0] sdram_addr;
   logic          sdram_rd;
   logic [7:0]    sdram_data;
   logic [VW-1:0] vfd_addr;
   logic [7:0]    vfd_dout;
   logic          vfd_vram_we;
   logic          frame_done;

   logic [7:0]    mem [2*SS];
   logic [7:0]    got [SS];

   int total = 0;
   int bad   = 0;

   typedef int iarr_t [GR*SG];
   iarr_t mI, h0, h1, h2;
   int pcnt = 0;
   int exp_idx = 0;
   int wcnt = 0;

   vfd_compositor #(
      .SCREEN_SIZE(SS), .ADDR_W(AW), .VADDR_W(VW), .GRIDS(GR),
      .SEGS(SG), .INT_W(IW), .DECAY_DIV(DD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .persist_en(persist_en),
      .grid_sel(grid_sel), .seg(seg), .rdy(rdy),
      .sdram_addr(sdram_addr), .sdram_rd(sdram_rd), .sdram_data(sdram_data),
      .vfd_addr(vfd_addr), .vfd_dout(vfd_dout), .vfd_vram_we(vfd_vram_we),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   assign sdram_data = mem[sdram_addr[3:0]];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Mask code -> flat intensity index, -1 for "no segment".
   function automatic int dec(input logic [7:0] m);
      int hi, lo, g, s;
      hi = int'(m[7:4]);
      lo = int'(m[3:0]);
      if (hi < GR) begin g = hi; s = lo; end
      else if (hi == 10) begin g = lo; s = 16; end
      else return -1;
      if (g >= GR || s >= SG) return -1;
      return g * SG + s;
   endfunction

   function automatic logic [7:0] comp(input logic [7:0] b, input int i);
      int r, g, bl, rr, gg, bb;
      r = int'(b[7:5]); g = int'(b[4:2]); bl = int'(b[1:0]);
      if (i == MAXI) return b;
      if (i == 0) return b & 8'h92;
      rr = (r * i) >> IW;  if ((r & 4) > rr) rr = r & 4;
      gg = (g * i) >> IW;  if ((g & 4) > gg) gg = g & 4;
      bb = (bl * i) >> IW; if ((bl & 2) > bb) bb = bl & 2;
      return 8'((rr << 5) | (gg << 2) | bb);
   endfunction

   // Reference model and scoreboard: intensities evolve on each clock; a write's
   // pixel uses the intensity seen two rdy-steps before its write step.
   initial begin
      int p, k, iv;
      bit tk;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            foreach (mI[j]) mI[j] = 0;
            h0 = mI; h1 = mI; h2 = mI;
            pcnt = 0; exp_idx = 0; wcnt = 0;
         end else begin
            if (rdy) begin h2 = h1; h1 = h0; h0 = mI; end
            tk = (pcnt == DD - 1);
            pcnt = tk ? 0 : pcnt + 1;
            if (tk && persist_en) foreach (mI[j]) if (mI[j] > 0) mI[j] = mI[j] - 1;
            if ($countones(grid_sel) == 1)
               for (int g = 0; g < GR; g++)
                  if (grid_sel[g])
                     for (int s = 0; s < SG; s++)
                        if (seg[s]) mI[g*SG+s] = MAXI;
                        else if (!persist_en) mI[g*SG+s] = 0;
         end
         @(negedge clk);
         if (vfd_vram_we === 1'b1) begin
            p  = exp_idx;
            k  = dec(mem[SS+p]);
            iv = (k < 0) ? 0 : h2[k];
            chk("wr_addr", 32'(vfd_addr), 32'(p));
            chk("wr_dout", 32'(vfd_dout), 32'(comp(mem[p], iv)));
            chk("wr_done", 32'(frame_done), 32'(p == SS - 1));
            if (vfd_addr < VW'(SS)) got[vfd_addr[2:0]] = vfd_dout;
            wcnt++;
            if (p == SS - 1) begin
               chk("frame_writes", 32'(wcnt), 32'(SS));
               wcnt = 0; exp_idx = 0;
            end else exp_idx++;
         end else if (frame_done === 1'b1) begin
            chk("done_needs_we", 32'(vfd_vram_we), 32'd1);
         end
      end
   end

   task automatic wait_done(input int budget);
      int n = 0;
      bit seen = 0;
      while (!seen && n < budget) begin
         @(negedge clk);
         n++;
         if (frame_done === 1'b1) seen = 1;
      end
      chk("frame_done_seen", 32'(seen), 32'd1);
   endtask

   task automatic run_frame();
      rdy = 1'b1;
      enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
      wait_done(200);
      @(negedge clk);
   endtask

   task automatic latch(input int g, input logic [SG-1:0] s);
      grid_sel = GR'(1) << g;
      seg = s;
      @(negedge clk);
      grid_sel = '0;
      seg = '0;
   endtask

   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      int frames, cyc;
      // Model self-pins.
      chk("model_full",  32'(comp(8'hFF, 15)), 32'h000000FF);
      chk("model_dark",  32'(comp(8'hFF, 0)),  32'h00000092);
      chk("model_i8",    32'(comp(8'hFF, 8)),  32'h00000092);
      chk("model_mix",   32'(comp(8'h6F, 8)),  32'h00000026);
      chk("model_dec16", 32'(dec(8'hA2)),      32'(2*SG+16));
      chk("model_decbad",32'(dec(8'hB0)),      32'hFFFFFFFF);

      mem[SS+0] = 8'h03; mem[0] = 8'hFF;
      mem[SS+1] = 8'h13; mem[1] = 8'hFF;
      mem[SS+2] = 8'hA2; mem[2] = 8'hFF;
      mem[SS+3] = 8'hB0; mem[3] = 8'hFF;
      mem[SS+4] = 8'h0F; mem[4] = 8'hFF;
      mem[SS+5] = 8'h03; mem[5] = 8'h6F;
      mem[SS+6] = 8'hA9; mem[6] = 8'hB6;
      mem[SS+7] = 8'hFF; mem[7] = 8'hFF;

      // Reset with enable held.
      rst_n = 1'b0; enable = 1'b1; rdy = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_sdram_addr", 32'(sdram_addr), 32'd0);
      chk("rst_sdram_rd",   32'(sdram_rd), 32'd0);
      chk("rst_vfd_addr",   32'(vfd_addr), 32'd0);
      chk("rst_vfd_dout",   32'(vfd_dout), 32'd0);
      chk("rst_we",         32'(vfd_vram_we), 32'd0);
      chk("rst_done",       32'(frame_done), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("first_addr", 32'(sdram_addr), 32'(SS));
      chk("first_rd",   32'(sdram_rd), 32'd1);
      enable = 1'b0;
      wait_done(200);
      @(negedge clk);

      // Binary lit/dark and seg-16 code.
      persist_en = 1'b0;
      latch(0, SG'(1) << 3);
      latch(2, SG'(1) << 16);
      run_frame();
      chk("bin_lit",    32'(got[0]), 32'hFF);
      chk("bin_unlit",  32'(got[1]), 32'h92);
      chk("seg16_lit",  32'(got[2]), 32'hFF);
      chk("code_b0",    32'(got[3]), 32'h92);
      chk("bin_lit_bg", 32'(got[5]), 32'h6F);
      latch(0, '0);
      run_frame();
      chk("bin_dark",    32'(got[0]), 32'h92);
      chk("bin_dark_bg", 32'(got[5]), 32'h02);

      // Illegal multi-hot grid strobe leaves intensities alone.
      latch(0, SG'(1) << 3);
      grid_sel = GR'(3); seg = '0;
      repeat (5) @(negedge clk);
      grid_sel = '0;
      run_frame();
      chk("multihot_ignored", 32'(got[0]), 32'hFF);

      // Persistence: latch, release, decay through several frames.
      persist_en = 1'b1;
      for (int k = 0; k < SS; k++) begin
         mem[SS+k] = 8'h03;
         mem[k] = 8'($urandom);
      end
      mem[0] = 8'hFF;
      latch(0, SG'(1) << 3);
      enable = 1'b1; rdy = 1'b1;
      wait_done(200);
      wait_done(200);
      wait_done(200);
      enable = 1'b0;
      repeat (4) @(negedge clk);
      run_frame();
      chk("decayed_to_dim", 32'(got[0]), 32'h92);

      // Latch held every cycle collides with ticks; latch must win.
      grid_sel = GR'(1); seg = SG'(1) << 3;
      run_frame();
      chk("latch_beats_tick", 32'(got[0]), 32'hFF);
      grid_sel = '0; seg = '0;

      // Randomized inputs with 50% rdy stalls over several frames.
      for (int k = 0; k < SS; k++) begin
         mem[SS+k] = {4'($urandom_range(0, 11)), 4'($urandom)};
         mem[k] = 8'($urandom);
      end
      frames = 0; cyc = 0;
      enable = 1'b1;
      while (frames < 6 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (frame_done === 1'b1) begin
            frames++;
            if (frames == 6) enable = 1'b0;
         end
         rdy = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 9))
            0:       grid_sel = GR'($urandom);
            1:       grid_sel = '0;
            default: grid_sel = GR'(1) << $urandom_range(0, GR - 1);
         endcase
         seg = SG'($urandom);
         if ($urandom_range(0, 19) == 0) persist_en = ~persist_en;
      end
      chk("random_frames", 32'(frames), 32'd6);
      enable = 1'b0; rdy = 1'b1; grid_sel = '0;
      repeat (10) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
